// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU/address/compare ops plus an iterative 32x32 shift-add multiply.
// Latency: single-cycle ops 1 cycle; MUL result visible 32 cycles after the accepting edge.
// Backpressure: stall_out is high while a multiply iterates; inputs are ignored until it drops.
module execute_stage #(
  parameter int         DATA_W  = 32,
  parameter logic [6:0] OPC_ADD = 7'h00,
  parameter logic [6:0] OPC_SUB = 7'h01,
  parameter logic [6:0] OPC_MUL = 7'h02,
  parameter logic [6:0] OPC_LDW = 7'h10,
  parameter logic [6:0] OPC_STW = 7'h11,
  parameter logic [6:0] OPC_BEQ = 7'h30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [6:0]        opcode,
  input  logic [4:0]        dst,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [9:0]        offsetlo,
  input  logic [DATA_W-1:0] in_pc,
  output logic              stall_out,
  output logic              out_valid,
  output logic [4:0]        out_dst,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target
);

  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

  state_t            state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [4:0]        count;
  logic [4:0]        mul_dst;

  logic [DATA_W-1:0] off_sext;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] addr;

  // Sign-extended immediate, effective address and next partial product.
  assign off_sext  = {{(DATA_W-10){offsetlo[9]}}, offsetlo};
  assign addr      = src1 + off_sext;
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
  assign stall_out = (state == MUL_BUSY);

  // FSM, multiplier datapath and registered result bundle. Strobes default low
  // every cycle so each valid/branch is a one-cycle pulse; data fields hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mcand          <= '0;
      mplier         <= '0;
      acc            <= '0;
      count          <= '0;
      mul_dst        <= '0;
      out_valid      <= 1'b0;
      out_dst        <= '0;
      out_result     <= '0;
      out_store_data <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
    end else begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      branch_taken  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (opcode)
              OPC_ADD: begin
                out_valid     <= 1'b1;
                out_result    <= src1 + src2;
                out_dst       <= dst;
                out_reg_write <= 1'b1;
              end
              OPC_SUB: begin
                out_valid     <= 1'b1;
                out_result    <= src1 - src2;
                out_dst       <= dst;
                out_reg_write <= 1'b1;
              end
              OPC_LDW: begin
                out_valid     <= 1'b1;
                out_result    <= addr;
                out_dst       <= dst;
                out_reg_write <= 1'b1;
                out_mem_read  <= 1'b1;
              end
              OPC_STW: begin
                out_valid      <= 1'b1;
                out_result     <= addr;
                out_dst        <= dst;
                out_store_data <= src2;
                out_mem_write  <= 1'b1;
              end
              OPC_BEQ: begin
                out_valid     <= 1'b1;
                out_dst       <= dst;
                branch_taken  <= (src1 == src2);
                branch_target <= in_pc + off_sext;
              end
              OPC_MUL: begin
                mcand   <= src1;
                mplier  <= src2;
                acc     <= '0;
                count   <= '0;
                mul_dst <= dst;
                state   <= MUL_BUSY;
              end
              default: ; // unknown opcode behaves as a NOP
            endcase
          end
        end
        MUL_BUSY: begin
          // One multiplier bit per cycle; always 32 iterations, no early exit.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            state         <= IDLE;
            out_valid     <= 1'b1;
            out_reg_write <= 1'b1;
            out_result    <= acc_next;
            out_dst       <= mul_dst;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Execute stage of the in-order pipeline. It sits directly downstream of the decode stage and consumes its registered opcode, dst, src1, src2 and offsetlo. It performs ALU, address-generation and compare operations in one cycle, and 32x32 multiply with an iterative shift-add FSM. While a multiply is busy it stalls the front end through stall_out, which drives decode's enable low.

Parameters:
DATA_W, 32, operand/result width (only 32 supported)
OPC_ADD, 7'h00, dst = src1 + src2
OPC_SUB, 7'h01, dst = src1 - src2
OPC_MUL, 7'h02, dst = low 32 bits of src1 * src2, multi-cycle
OPC_LDW, 7'h10, load word: addr = src1 + sext(offsetlo)
OPC_STW, 7'h11, store word: addr = src1 + sext(offsetlo), data = src2
OPC_BEQ, 7'h30, branch if src1 == src2; target = in_pc + sext(offsetlo)

Ports:
clk  in  1  clock; all state on the rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  decode outputs hold a valid instruction this cycle
opcode  in  7  from decode
dst  in  5  destination register from decode
src1  in  32  operand 1 from decode
src2  in  32  operand 2 from decode
offsetlo  in  10  immediate from decode; two's complement
in_pc  in  32  PC of the instruction
stall_out  out  1  multiply busy; front end must hold
out_valid  out  1  result bundle valid (one-cycle pulse per instruction)
out_dst  out  5  destination register
out_result  out  32  ALU result, product, or memory address
out_store_data  out  32  store data (src2) for STW
out_reg_write  out  1  writeback must write out_dst
out_mem_read  out  1  LDW strobe
out_mem_write  out  1  STW strobe
branch_taken  out  1  one-cycle pulse; redirect fetch and flush younger instructions
branch_target  out  32  valid when branch_taken = 1

Behaviour:
- Reset (async, rst_n = 0):
  - All outputs clear to 0.
  - FSM returns to IDLE; the multiply counter and operand/accumulator registers clear.
  - An in-flight multiply is abandoned and produces no output.
- FSM has two states: IDLE and MUL_BUSY.
- Instruction acceptance:
  - An instruction is accepted only when state = IDLE and in_valid = 1.
  - In MUL_BUSY, in_valid and all data inputs are ignored. Upstream holds the pending instruction because stall_out = 1.
- Single-cycle ops (ADD/SUB/LDW/STW/BEQ):
  - All outputs are registered.
  - out_valid = 1 for exactly the cycle after the accepting edge.
  - ADD/SUB: out_result wraps mod 2^32, no overflow flag. out_reg_write = 1.
  - LDW: out_result = src1 + sext(offsetlo), out_mem_read = 1, out_reg_write = 1.
  - STW: out_result = address, out_store_data = src2, out_mem_write = 1, out_reg_write = 0.
  - BEQ: out_reg_write = 0. If src1 == src2, branch_taken = 1 and branch_target = in_pc + sext(offsetlo), mod 2^32; otherwise branch_taken = 0.
- Unknown opcode: treated as NOP. out_valid = 0 and all strobes 0.
- in_valid = 0 in IDLE: out_valid and all strobes go to 0 next cycle. out_result, out_dst, out_store_data and branch_target hold their previous values.
- MUL:
  - Accepting edge E0 latches mcand = src1, mplier = src2, acc = 0, count = 0 and dst, then enters MUL_BUSY. out_valid = 0 after E0.
  - Each edge in MUL_BUSY:
    - acc += mplier[0] ? mcand : 0
    - mcand <<= 1, mplier >>= 1, count++
  - On the edge with count = 31 (edge E32):
    - FSM returns to IDLE.
    - out_result = final acc, low 32 bits.
    - out_reg_write = 1, out_valid = 1 for one cycle.
  - Latency: the result is visible after E32.
- stall_out = (state == MUL_BUSY), combinational from the state register. It is high for exactly 32 cycles per MUL, from after E0 through before E32.
- Back-to-back ops:
  - An instruction presented while stall_out = 1 is accepted on the first edge after stall_out falls, i.e. E33 when it is held.
  - Consecutive single-cycle ops issue every cycle with no bubble.
- Multiply by zero still takes 32 cycles; no early exit.

Test Plan:
- Reset then ADD: src1 = 5, src2 = 7, dst = 3 -> next cycle out_valid = 1, out_result = 12, out_dst = 3, out_reg_write = 1. SUB with src1 = 3, src2 = 5 -> out_result = 32'hFFFFFFFE.
- MUL: src1 = 32'hFFFFFFFF, src2 = 3 -> stall_out high exactly 32 cycles, then out_valid with out_result = 32'hFFFFFFFD. Next, ADD held during the stall -> accepted at E33, result appears one cycle later. No instruction is lost or duplicated.
- LDW: src1 = 32'h100, offsetlo = 10'h3FC -> out_result = 32'hFC, out_mem_read = 1. STW: src2 = 32'hDEAD -> out_store_data = 32'hDEAD, out_mem_write = 1, out_reg_write = 0.
- BEQ: src1 = src2 = 9, in_pc = 32'h40, offsetlo = 10'h010 -> branch_taken one-cycle pulse, branch_target = 32'h50. BEQ with unequal operands -> branch_taken stays 0.
- Reset mid-MUL: assert rst_n = 0 at busy cycle 10 -> stall_out and all outputs 0 immediately (asynchronously). After release, the next ADD completes normally with no stale product.
- Unknown opcode 7'h7F with in_valid = 1 -> out_valid and all strobes stay 0.
